rfft_pe_sched: RTL and testbench

Stage/group scheduler for the 4-input butterfly processing element of the RFFT datapath. On `start` it walks every stage and every 4-sample group: it issues sample-memory reads, twiddle-ROM addresses and the per-group `bypass_n` aligned to the PE pipeline, and it generates write-back strobes delayed by the memory plus PE latency. It sits between the top-level FFT control (start/done) and the sample RAM, twiddle ROM and `pe` instance. Between stages it enforces a drain barrier so that no read overtakes a pending write.

---
 rtl/rfft_pe_sched.sv | 177 +++++++++++++++++
 tb/tb_rfft_pe_sched.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/rfft_pe_sched.sv
// Stage/group scheduler for the 4-input butterfly PE of the RFFT datapath.
// Issues one group read per cycle, with the twiddle address and a bypass flag.
// It replays the reads as write-back strobes once the memory and PE latency
// have elapsed, and holds back each new stage until all its writes have drained.
module rfft_pe_sched #(
  parameter int ADDR_W = 6,
  parameter int NSTAGE = 4,
  parameter int RD_LAT = 1,
  parameter int PE_LAT = 4
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              start,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic [2:0]        stage,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [ADDR_W-1:0] tf_addr,
  output logic              bypass_n,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr
);

  localparam int D     = RD_LAT + PE_LAT;
  localparam int CNT_W = $clog2(D + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] g_q, g_d;
  logic [2:0]        stage_q, stage_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q, tf_addr_q;

  // Group issued in the coming cycle (if any); the first group of a stage is
  // launched directly from IDLE or from the last DRAIN cycle so that reads
  // follow the previous stage's final write with no idle cycle in between.
  logic              issue;
  logic [ADDR_W-1:0] issue_g;
  logic [2:0]        issue_stage;
  logic [ADDR_W-1:0] tf_d;

  // Delay lines following the issued reads down to the write-back port.
  logic              vld_q  [D];
  logic [ADDR_W-1:0] waddr_q[D];
  logic              byp_n_q[D];

  // Next-state, issue decision and twiddle address.
  always_comb begin
    state_d     = state_q;
    g_d         = g_q;
    stage_d     = stage_q;
    cnt_d       = cnt_q;
    done_d      = 1'b0;
    issue       = 1'b0;
    issue_g     = g_q;
    issue_stage = stage_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          issue       = 1'b1;
          issue_g     = '0;
          stage_d     = '0;
          issue_stage = '0;
        end
      end
      S_ISSUE: begin
        if (!hold) begin
          issue = 1'b1;
        end
      end
      S_DRAIN: begin
        if (cnt_q == '0) begin
          if (int'(stage_q) < NSTAGE - 1) begin
            issue       = 1'b1;
            issue_g     = '0;
            stage_d     = stage_q + 3'd1;
            issue_stage = stage_q + 3'd1;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (issue) begin
      if (issue_g == '1) begin
        state_d = S_DRAIN;
        cnt_d   = CNT_W'(D);
        g_d     = '0;
      end else begin
        state_d = S_ISSUE;
        g_d     = issue_g + 1'b1;
      end
    end
    tf_d   = issue_g << issue_stage;
    busy_d = (state_d != S_IDLE);
  end

  // FSM state, group/stage counters and drain counter.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      g_q     <= '0;
      stage_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      stage_q <= stage_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Read-side output registers; addresses hold their last issued value.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      tf_addr_q <= '0;
    end else begin
      rd_en_q <= issue;
      if (issue) begin
        rd_addr_q <= issue_g;
        tf_addr_q <= tf_d;
      end
    end
  end

  // Write-back and bypass delay lines; cleared on reset to drop in-flight writes.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      for (int i = 0; i < D; i++) begin
        vld_q[i]   <= 1'b0;
        waddr_q[i] <= '0;
        byp_n_q[i] <= 1'b1;
      end
    end else begin
      vld_q[0]   <= rd_en_q;
      waddr_q[0] <= rd_addr_q;
      byp_n_q[0] <= !(issue && (tf_d == '0));
      for (int i = 1; i < D; i++) begin
        vld_q[i]   <= vld_q[i-1];
        waddr_q[i] <= waddr_q[i-1];
        byp_n_q[i] <= byp_n_q[i-1];
      end
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign stage    = stage_q;
  assign rd_en    = rd_en_q;
  assign rd_addr  = rd_addr_q;
  assign tf_addr  = tf_addr_q;
  assign bypass_n = byp_n_q[D-1];
  assign wr_en    = vld_q[D-1];
  assign wr_addr  = waddr_q[D-1];

endmodule

// File: tb/tb_rfft_pe_sched.sv
// Bench for rfft_pe_sched: default-size instance driven through full transforms,
// hold, mid-run reset and continuous start, plus a one-stage 4-group instance.
module tb_rfft_pe_sched;

  localparam int AW = 6;
  localparam int NS = 4;
  localparam int RL = 1;
  localparam int PL = 4;
  localparam int G  = 1 << AW;
  localparam int D  = RL + PL;
  localparam int P  = G + D;

  typedef struct {
    int cyc;
    int addr;
  } wr_t;

  logic          Clk = 1'b0;
  logic          Reset, start, hold, start_s;
  logic          busy, done, rd_en, bypass_n, wr_en;
  logic [2:0]    stage;
  logic [AW-1:0] rd_addr, tf_addr, wr_addr;
  logic          s_busy, s_done, s_rd_en, s_bypass_n, s_wr_en;
  logic [2:0]    s_stage;
  logic [1:0]    s_rd_addr, s_tf_addr, s_wr_addr;

  int  checks   = 0;
  int  failures = 0;
  wr_t q_wr[$];
  int  q_byp[$];

  always #5 Clk = ~Clk;

  rfft_pe_sched #(.ADDR_W(AW), .NSTAGE(NS), .RD_LAT(RL), .PE_LAT(PL)) u_dut (
    .Clk(Clk), .Reset(Reset), .start(start), .hold(hold),
    .busy(busy), .done(done), .stage(stage), .rd_en(rd_en),
    .rd_addr(rd_addr), .tf_addr(tf_addr), .bypass_n(bypass_n),
    .wr_en(wr_en), .wr_addr(wr_addr)
  );

  rfft_pe_sched #(.ADDR_W(2), .NSTAGE(1), .RD_LAT(1), .PE_LAT(4)) u_small (
    .Clk(Clk), .Reset(Reset), .start(start_s), .hold(1'b0),
    .busy(s_busy), .done(s_done), .stage(s_stage), .rd_en(s_rd_en),
    .rd_addr(s_rd_addr), .tf_addr(s_tf_addr), .bypass_n(s_bypass_n),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_stage"}, stage, 0);
    chk({tag, "_rd_en"}, rd_en, 0);
    chk({tag, "_rd_addr"}, rd_addr, 0);
    chk({tag, "_tf_addr"}, tf_addr, 0);
    chk({tag, "_bypass_n"}, bypass_n, 1);
    chk({tag, "_wr_en"}, wr_en, 0);
    chk({tag, "_wr_addr"}, wr_addr, 0);
  endtask

  // One transform from IDLE. The caller is in cycle 0. Reads are blanked in
  // cycles gap_lo..gap_lo+gap_n-1; hold is sampled on the edge closing the
  // cycle, so it is asserted one cycle earlier than the blanked reads.
  task automatic run_full(input int gap_lo, input int gap_n);
    int   done_c, t, s, p, exp_tf;
    logic exp_rd, exp_byp;
    wr_t  e;
    done_c = NS * P + 1 + gap_n;
    q_wr.delete();
    q_byp.delete();
    s = 0;
    p = 0;
    start = 1'b1;
    for (int c = 1; c <= done_c + 1; c++) begin
      @(posedge Clk);
      #1;
      start = 1'b0;
      hold  = (gap_n > 0 && c >= gap_lo - 1 && c <= gap_lo + gap_n - 2);
      @(negedge Clk);
      exp_rd = 1'b0;
      if (!(gap_n > 0 && c >= gap_lo && c < gap_lo + gap_n)) begin
        t = c - 1 - ((gap_n > 0 && c >= gap_lo + gap_n) ? gap_n : 0);
        s = t / P;
        p = t % P;
        if (s < NS && p < G) exp_rd = 1'b1;
      end
      chk("rd_en", rd_en, exp_rd);
      if (exp_rd) begin
        exp_tf = (p << s) % G;
        chk("rd_addr", rd_addr, p);
        chk("tf_addr", tf_addr, exp_tf);
        chk("stage", stage, s);
        q_wr.push_back('{c + D, p});
        if (exp_tf == 0) q_byp.push_back(c + D - 1);
      end
      exp_byp = (q_byp.size() > 0 && q_byp[0] == c);
      if (exp_byp) void'(q_byp.pop_front());
      chk("bypass_n", bypass_n, !exp_byp);
      if (q_wr.size() > 0 && q_wr[0].cyc == c) begin
        e = q_wr.pop_front();
        chk("wr_en", wr_en, 1);
        chk("wr_addr", wr_addr, e.addr);
      end else begin
        chk("wr_en", wr_en, 0);
      end
      chk("busy", busy, c <= done_c);
      chk("done", done, c == done_c);
    end
    hold = 1'b0;
    chk("wr_pending", q_wr.size(), 0);
    chk("byp_pending", q_byp.size(), 0);
  endtask

  initial begin
    Reset   = 1'b1;
    start   = 1'b0;
    hold    = 1'b0;
    start_s = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;
    @(negedge Clk);
    check_reset_vals("init");
    chk("init_s_busy", s_busy, 0);
    chk("init_s_bypass_n", s_bypass_n, 1);
    @(posedge Clk);
    #1;

    // Plain transform, then one with a 3-cycle hold in stage 0.
    run_full(0, 0);
    run_full(10, 3);

    // Reset pulsed in cycle 30 of a transform; everything in flight is dropped.
    start = 1'b1;
    repeat (30) begin
      @(posedge Clk);
      #1;
      start = 1'b0;
    end
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    for (int c = 31; c <= 45; c++) begin
      @(negedge Clk);
      check_reset_vals("after_rst");
      @(posedge Clk);
      #1;
    end
    run_full(0, 0);

    // start held high: a new transform only begins from IDLE.
    start = 1'b1;
    for (int c = 1; c <= 556; c++) begin
      @(posedge Clk);
      #1;
      @(negedge Clk);
      chk("cont_done", done, (c == 277 || c == 555));
      chk("cont_busy", busy, (c != 278 && c != 556));
      if (c == 1 || c == 279) begin
        chk("cont_rd_en", rd_en, 1);
        chk("cont_rd_addr", rd_addr, 0);
        chk("cont_stage", stage, 0);
      end
      if (c == 278) chk("cont_rd_idle", rd_en, 0);
    end
    start = 1'b0;

    // Single stage with four groups.
    start_s = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      @(posedge Clk);
      #1;
      start_s = 1'b0;
      @(negedge Clk);
      chk("s_rd_en", s_rd_en, (c >= 1 && c <= 4));
      if (c >= 1 && c <= 4) begin
        chk("s_rd_addr", s_rd_addr, c - 1);
        chk("s_tf_addr", s_tf_addr, c - 1);
      end
      chk("s_wr_en", s_wr_en, (c >= 6 && c <= 9));
      if (c >= 6 && c <= 9) chk("s_wr_addr", s_wr_addr, c - 6);
      chk("s_bypass_n", s_bypass_n, (c != 5));
      chk("s_done", s_done, (c == 10));
      chk("s_busy", s_busy, (c <= 10));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
